adbg_mem_arbiter: RTL and testbench



---
 rtl/adbg_arb_pkg.sv | 5 +
 rtl/adbg_rr_arbiter.sv | 27 ++
 rtl/adbg_mem_arbiter.sv | 109 ++++++++++
 tb/tb_adbg_mem_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/adbg_arb_pkg.sv
// adbg_arb_pkg: FSM state encoding and default abort limit shared by the debug memory arbiter.
package adbg_arb_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ABORT} arb_state_e;
   localparam int TIMEOUT_CYCLES_DEF = 1024;
endpackage

// File: rtl/adbg_rr_arbiter.sv
// adbg_rr_arbiter: combinational round-robin picker, searching upward from ptr_i with wrap.
module adbg_rr_arbiter #(
   parameter int NB_REQ = 2,
   parameter int IW     = $clog2(NB_REQ)
) (
   input  logic [NB_REQ-1:0] req_i,
   input  logic [IW-1:0]     ptr_i,
   output logic [NB_REQ-1:0] gnt_o,
   output logic [IW-1:0]     idx_o
);
   int   j;
   logic found;
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      j     = 0;
      for (int i = 0; i < NB_REQ; i++) begin
         j = (int'(ptr_i) + i) % NB_REQ;
         if (!found && req_i[j]) begin
            found    = 1'b1;
            gnt_o[j] = 1'b1;
            idx_o    = IW'(j);
         end
      end
   end
endmodule

// File: rtl/adbg_mem_arbiter.sv
// adbg_mem_arbiter: round-robin arbiter funnelling NB_REQ debug requesters onto one downstream
// port with a single access outstanding and a timeout that aborts hung accesses.
module adbg_mem_arbiter
   import adbg_arb_pkg::*;
#(
   parameter int NB_REQ         = 2,
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic                             axi_aclk,
   input  logic                             axi_aresetn,
   input  logic [NB_REQ-1:0]                req_i,
   input  logic [NB_REQ-1:0]                we_i,
   input  logic [NB_REQ*ADDR_WIDTH-1:0]     addr_i,
   input  logic [NB_REQ*DATA_WIDTH-1:0]     wdata_i,
   input  logic [NB_REQ*(DATA_WIDTH/8)-1:0] be_i,
   output logic [NB_REQ-1:0]                gnt_o,
   output logic [NB_REQ-1:0]                rvalid_o,
   output logic [DATA_WIDTH-1:0]            rdata_o,
   output logic                             err_o,
   output logic                             mst_req_o,
   output logic                             mst_we_o,
   output logic [ADDR_WIDTH-1:0]            mst_addr_o,
   output logic [DATA_WIDTH-1:0]            mst_wdata_o,
   output logic [DATA_WIDTH/8-1:0]          mst_be_o,
   input  logic                             mst_gnt_i,
   input  logic                             mst_rvalid_i,
   input  logic [DATA_WIDTH-1:0]            mst_rdata_i,
   input  logic                             mst_err_i,
   output logic                             busy_o
);
   localparam int IW = $clog2(NB_REQ);
   localparam int BW = DATA_WIDTH / 8;
   localparam int CW = $clog2(TIMEOUT_CYCLES);

   arb_state_e            state_q;
   logic [IW-1:0]         rr_q, owner_q, win_idx, rr_nxt;
   logic [CW-1:0]         cnt_q;
   logic                  we_q, err_q, active, done, tmo;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
   logic [BW-1:0]         be_q;
   logic [NB_REQ-1:0]     rvalid_q, win_gnt, owner_oh;

   adbg_rr_arbiter #(.NB_REQ(NB_REQ), .IW(IW)) u_rr (
      .req_i (req_i),
      .ptr_i (rr_q),
      .gnt_o (win_gnt),
      .idx_o (win_idx)
   );

   // A grant together with a response in ISSUE is a complete access
   assign active   = state_q == ISSUE || state_q == WAIT;
   assign done     = (state_q == ISSUE && mst_gnt_i && mst_rvalid_i) || (state_q == WAIT && mst_rvalid_i);
   assign tmo      = active && !done && cnt_q == CW'(TIMEOUT_CYCLES - 1);
   assign owner_oh = NB_REQ'(1) << owner_q;
   assign rr_nxt   = (owner_q == IW'(NB_REQ - 1)) ? '0 : owner_q + 1'b1;

   assign gnt_o       = (state_q == IDLE && axi_aresetn) ? win_gnt : '0;
   assign rvalid_o    = rvalid_q;
   assign rdata_o     = rdata_q;
   assign err_o       = err_q;
   assign mst_req_o   = state_q == ISSUE;
   assign mst_we_o    = we_q;
   assign mst_addr_o  = addr_q;
   assign mst_wdata_o = wdata_q;
   assign mst_be_o    = be_q;
   assign busy_o      = state_q != IDLE;

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         state_q  <= IDLE;
         rr_q     <= '0;
         cnt_q    <= '0;
         owner_q  <= '0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         be_q     <= '0;
         rvalid_q <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         rvalid_q <= '0;
         cnt_q    <= active ? cnt_q + 1'b1 : '0;
         if (done || tmo) begin
            rvalid_q <= owner_oh;
            rdata_q  <= done ? mst_rdata_i : '0;
            err_q    <= done ? mst_err_i : 1'b1;
            rr_q     <= rr_nxt;
         end
         case (state_q)
            IDLE: if (|req_i) begin
               owner_q <= win_idx;
               we_q    <= we_i[win_idx];
               addr_q  <= addr_i[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
               wdata_q <= wdata_i[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
               be_q    <= be_i[int'(win_idx)*BW +: BW];
               state_q <= ISSUE;
            end
            // A command accepted at the timeout still owes a response, which ABORT absorbs
            ISSUE:   state_q <= done ? IDLE : mst_gnt_i ? (tmo ? ABORT : WAIT) : (tmo ? IDLE : ISSUE);
            WAIT:    state_q <= done ? IDLE : tmo ? ABORT : WAIT;
            default: state_q <= mst_rvalid_i ? IDLE : ABORT;
         endcase
      end
   end
endmodule

// File: tb/tb_adbg_mem_arbiter.sv
// tb_adbg_mem_arbiter: directed scenarios for the debug memory arbiter with NB_REQ=2, TIMEOUT_CYCLES=16.
module tb_adbg_mem_arbiter;
   localparam int N = 2, AW = 32, DW = 32, BW = 4, T = 16;

   logic            axi_aclk = 1'b0, axi_aresetn;
   logic [N-1:0]    req_i, we_i, gnt_o, rvalid_o;
   logic [N*AW-1:0] addr_i;
   logic [N*DW-1:0] wdata_i;
   logic [N*BW-1:0] be_i;
   logic [DW-1:0]   rdata_o, mst_wdata_o, mst_rdata_i;
   logic [AW-1:0]   mst_addr_o;
   logic [BW-1:0]   mst_be_o;
   logic            err_o, mst_req_o, mst_we_o, mst_gnt_i, mst_rvalid_i, mst_err_i, busy_o;
   int              chk_cnt = 0, pass_cnt = 0;

   adbg_mem_arbiter #(.NB_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)) dut (
      .axi_aclk     (axi_aclk),
      .axi_aresetn  (axi_aresetn),
      .req_i        (req_i),
      .we_i         (we_i),
      .addr_i       (addr_i),
      .wdata_i      (wdata_i),
      .be_i         (be_i),
      .gnt_o        (gnt_o),
      .rvalid_o     (rvalid_o),
      .rdata_o      (rdata_o),
      .err_o        (err_o),
      .mst_req_o    (mst_req_o),
      .mst_we_o     (mst_we_o),
      .mst_addr_o   (mst_addr_o),
      .mst_wdata_o  (mst_wdata_o),
      .mst_be_o     (mst_be_o),
      .mst_gnt_i    (mst_gnt_i),
      .mst_rvalid_i (mst_rvalid_i),
      .mst_rdata_i  (mst_rdata_i),
      .mst_err_i    (mst_err_i),
      .busy_o       (busy_o)
   );

   always #5 axi_aclk = ~axi_aclk;

   task automatic tick;
      @(posedge axi_aclk);
      #1;
   endtask

   task automatic idle_inputs;
      req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0; be_i = '0;
      mst_gnt_i = 1'b0; mst_rvalid_i = 1'b0; mst_rdata_i = '0; mst_err_i = 1'b0;
   endtask

   task automatic do_reset;
      axi_aresetn = 1'b0;
      idle_inputs();
      #2;
      axi_aresetn = 1'b1;
   endtask

   task automatic test_reset;
      axi_aresetn = 1'b0;
      idle_inputs();
      req_i = 2'b11;
      #2;
      chk_cnt++; if (gnt_o !== 2'b00) $display("FAIL rst_gnt got %b want 00", gnt_o); else pass_cnt++;
      chk_cnt++; if ({busy_o, mst_req_o, err_o, rvalid_o} !== 5'b0) $display("FAIL rst_ctrl got %b want 00000", {busy_o, mst_req_o, err_o, rvalid_o}); else pass_cnt++;
      chk_cnt++; if ({rdata_o, mst_addr_o} !== 64'h0) $display("FAIL rst_data got %h want 0", {rdata_o, mst_addr_o}); else pass_cnt++;
      tick();
      req_i = '0;
      axi_aresetn = 1'b1;
   endtask

   task automatic test_single_read;
      req_i = 2'b01; addr_i[31:0] = 32'h1000;
      #1;
      chk_cnt++; if (gnt_o !== 2'b01) $display("FAIL rd_gnt got %b want 01", gnt_o); else pass_cnt++;
      tick();
      req_i = '0; mst_gnt_i = 1'b1; mst_rvalid_i = 1'b1; mst_rdata_i = 32'hCAFEF00D;
      #1;
      chk_cnt++; if ({mst_req_o, mst_we_o, mst_addr_o} !== {1'b1, 1'b0, 32'h1000}) $display("FAIL rd_cmd got %b/%b/%h want 1/0/00001000", mst_req_o, mst_we_o, mst_addr_o); else pass_cnt++;
      tick();
      mst_gnt_i = 1'b0; mst_rvalid_i = 1'b0; mst_rdata_i = '0;
      #1;
      chk_cnt++; if (rvalid_o !== 2'b01) $display("FAIL rd_rvalid got %b want 01", rvalid_o); else pass_cnt++;
      chk_cnt++; if ({rdata_o, err_o, busy_o} !== {32'hCAFEF00D, 2'b00}) $display("FAIL rd_data got %h/%b/%b want cafef00d/0/0", rdata_o, err_o, busy_o); else pass_cnt++;
      tick();
      chk_cnt++; if ({rvalid_o, rdata_o} !== {2'b00, 32'hCAFEF00D}) $display("FAIL rd_hold got %b/%h want 00/cafef00d", rvalid_o, rdata_o); else pass_cnt++;
   endtask

   task automatic test_round_robin;
      logic [N-1:0] exp_g, exp_rv;
      do_reset();
      tick();
      req_i = 2'b11;
      for (int k = 0; k < 8; k++) begin
         mst_gnt_i = mst_req_o; mst_rvalid_i = mst_req_o; mst_rdata_i = DW'(k);
         #1;
         exp_g  = (k % 2 != 0) ? 2'b00 : (k % 4 == 0) ? 2'b01 : 2'b10;
         exp_rv = (k == 0 || k % 2 != 0) ? 2'b00 : (k % 4 == 2) ? 2'b01 : 2'b10;
         chk_cnt++; if (gnt_o !== exp_g) $display("FAIL rr_gnt[%0d] got %b want %b", k, gnt_o, exp_g); else pass_cnt++;
         chk_cnt++; if (rvalid_o !== exp_rv) $display("FAIL rr_rvalid[%0d] got %b want %b", k, rvalid_o, exp_rv); else pass_cnt++;
         tick();
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_write_stall;
      req_i = 2'b10; we_i = 2'b10; addr_i[63:32] = 32'hA5A50004; wdata_i[63:32] = 32'h12345678; be_i[7:4] = 4'b0110;
      #1;
      chk_cnt++; if (gnt_o !== 2'b10) $display("FAIL wr_gnt got %b want 10", gnt_o); else pass_cnt++;
      tick();
      req_i = '0; we_i = '0; addr_i = '1; wdata_i = '1; be_i = '1;
      for (int k = 1; k <= 6; k++) begin
         mst_gnt_i = (k == 6);
         #1;
         chk_cnt++;
         if ({mst_req_o, mst_we_o, mst_addr_o, mst_wdata_o, mst_be_o} !== {1'b1, 1'b1, 32'hA5A50004, 32'h12345678, 4'b0110})
            $display("FAIL wr_stable[%0d] got %b/%b/%h/%h/%b want 1/1/a5a50004/12345678/0110", k, mst_req_o, mst_we_o, mst_addr_o, mst_wdata_o, mst_be_o);
         else pass_cnt++;
         tick();
      end
      mst_gnt_i = 1'b0; mst_rvalid_i = 1'b1; mst_rdata_i = 32'h55;
      #1;
      chk_cnt++; if ({mst_req_o, busy_o, rvalid_o} !== 4'b0100) $display("FAIL wr_wait got %b want 0100", {mst_req_o, busy_o, rvalid_o}); else pass_cnt++;
      tick();
      idle_inputs();
      #1;
      chk_cnt++; if ({rvalid_o, err_o} !== 3'b100) $display("FAIL wr_rvalid got %b want 100", {rvalid_o, err_o}); else pass_cnt++;
      tick();
      chk_cnt++; if (rvalid_o !== 2'b00) $display("FAIL wr_single got %b want 00", rvalid_o); else pass_cnt++;
   endtask

   task automatic test_timeout;
      logic seen;
      seen = 1'b0;
      req_i = 2'b01;
      tick();
      req_i = '0; mst_gnt_i = 1'b1;
      tick();
      mst_gnt_i = 1'b0;
      for (int k = 2; k <= 16; k++) begin
         #1;
         if (rvalid_o !== 2'b00) seen = 1'b1;
         tick();
      end
      req_i = 2'b10;
      #1;
      chk_cnt++; if (seen !== 1'b0) $display("FAIL to_early got %b want 0", seen); else pass_cnt++;
      chk_cnt++; if ({rvalid_o, err_o, busy_o} !== 4'b0111) $display("FAIL to_pulse got %b want 0111", {rvalid_o, err_o, busy_o}); else pass_cnt++;
      chk_cnt++; if (rdata_o !== 32'h0) $display("FAIL to_rdata got %h want 00000000", rdata_o); else pass_cnt++;
      chk_cnt++; if (gnt_o !== 2'b00) $display("FAIL to_abort_gnt got %b want 00", gnt_o); else pass_cnt++;
      tick();
      mst_rvalid_i = 1'b1; mst_rdata_i = 32'hDEAD;
      #1;
      chk_cnt++; if (gnt_o !== 2'b00) $display("FAIL to_abort_gnt2 got %b want 00", gnt_o); else pass_cnt++;
      tick();
      mst_rvalid_i = 1'b0; mst_rdata_i = '0;
      #1;
      chk_cnt++; if ({rvalid_o, err_o, rdata_o} !== {3'b001, 32'h0}) $display("FAIL to_discard got %b/%b/%h want 00/1/00000000", rvalid_o, err_o, rdata_o); else pass_cnt++;
      chk_cnt++; if (gnt_o !== 2'b10) $display("FAIL to_next_gnt got %b want 10", gnt_o); else pass_cnt++;
      tick();
      req_i = '0; mst_gnt_i = 1'b1; mst_rvalid_i = 1'b1; mst_rdata_i = 32'hBEEF;
      tick();
      idle_inputs();
      #1;
      chk_cnt++; if ({rvalid_o, err_o, rdata_o} !== {3'b100, 32'hBEEF}) $display("FAIL to_recover got %b/%b/%h want 10/0/0000beef", rvalid_o, err_o, rdata_o); else pass_cnt++;
      tick();
   endtask

   task automatic test_reset_mid;
      req_i = 2'b01;
      tick();
      req_i = '0; mst_gnt_i = 1'b1; mst_rvalid_i = 1'b1; mst_rdata_i = 32'h1111;
      tick();
      idle_inputs();
      req_i = 2'b11;
      #1;
      chk_cnt++; if (gnt_o !== 2'b10) $display("FAIL rm_pre_gnt got %b want 10", gnt_o); else pass_cnt++;
      tick();
      mst_gnt_i = 1'b1;
      tick();
      mst_gnt_i = 1'b0;
      #1;
      axi_aresetn = 1'b0;
      #1;
      chk_cnt++; if ({gnt_o, rvalid_o, busy_o, mst_req_o, err_o} !== 7'b0) $display("FAIL rm_ctrl got %b want 0000000", {gnt_o, rvalid_o, busy_o, mst_req_o, err_o}); else pass_cnt++;
      chk_cnt++; if ({rdata_o, mst_addr_o} !== 64'h0) $display("FAIL rm_data got %h want 0", {rdata_o, mst_addr_o}); else pass_cnt++;
      req_i = '0;
      #2;
      axi_aresetn = 1'b1;
      tick();
      mst_rvalid_i = 1'b1; mst_rdata_i = 32'h9999;
      tick();
      mst_rvalid_i = 1'b0;
      #1;
      chk_cnt++; if ({rvalid_o, rdata_o} !== {2'b00, 32'h0}) $display("FAIL rm_stray got %b/%h want 00/00000000", rvalid_o, rdata_o); else pass_cnt++;
      req_i = 2'b11;
      #1;
      chk_cnt++; if (gnt_o !== 2'b01) $display("FAIL rm_first_gnt got %b want 01", gnt_o); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_round_robin();
      test_write_stall();
      test_timeout();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
